// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/gnt/rvalid, feeds {pc+4, instr} downstream.
// Optional build macro IF_STALL_COUNT_EN adds a saturating stall_cycles counter output.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid
`ifdef IF_STALL_COUNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_KILL  = 3'd4;

  logic [2:0]      state, state_nxt;
  logic [XLEN-1:0] pc_reg, pc_reg_nxt;
  logic [XLEN-1:0] buf_pc, buf_pc_nxt;
  logic [XLEN-1:0] buf_instr, buf_instr_nxt;
  logic [XLEN-1:0] pc_nxt, instruction_nxt;
  logic            valid_nxt;
  logic            deliver;
  logic [XLEN-1:0] deliver_pc, deliver_instr;
  logic [XLEN-1:0] pc_inc, target;

  assign pc_inc    = pc_reg + XLEN'(4);
  assign target    = branch_addr & ~XLEN'(3);
  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc_reg;

  // Next-state, PC and output-register selection; branch wins over freeze and rvalid.
  always_comb begin
    state_nxt       = state;
    pc_reg_nxt      = pc_reg;
    buf_pc_nxt      = buf_pc;
    buf_instr_nxt   = buf_instr;
    deliver         = 1'b0;
    deliver_pc      = pc_inc;
    deliver_instr   = imem_rdata;
    pc_nxt          = pc;
    instruction_nxt = instruction;
    valid_nxt       = valid;

    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
        if (branch_taken) pc_reg_nxt = target;
      end
      ST_FETCH: begin
        if (branch_taken) begin
          pc_reg_nxt = target;
          state_nxt  = imem_gnt ? ST_KILL : ST_FETCH;
        end else if (imem_gnt) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (branch_taken) begin
          pc_reg_nxt = target;
          state_nxt  = imem_rvalid ? ST_FETCH : ST_KILL;
        end else if (imem_rvalid) begin
          pc_reg_nxt = pc_inc;
          if (freeze) begin
            buf_pc_nxt    = pc_inc;
            buf_instr_nxt = imem_rdata;
            state_nxt     = ST_HOLD;
          end else begin
            deliver   = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_KILL: begin
        if (branch_taken) pc_reg_nxt = target;
        // The squashed response still has to drain before a new request may issue.
        if (imem_rvalid) state_nxt = ST_FETCH;
      end
      ST_HOLD: begin
        if (branch_taken) begin
          pc_reg_nxt = target;
          state_nxt  = ST_FETCH;
        end else if (!freeze) begin
          deliver       = 1'b1;
          deliver_pc    = buf_pc;
          deliver_instr = buf_instr;
          state_nxt     = ST_FETCH;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (branch_taken || (!freeze && !deliver)) begin
      pc_nxt          = '0;
      instruction_nxt = '0;
      valid_nxt       = 1'b0;
    end else if (deliver) begin
      pc_nxt          = deliver_pc;
      instruction_nxt = deliver_instr;
      valid_nxt       = 1'b1;
    end
  end

  // State, PC, hold buffer and downstream-facing registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pc_reg      <= RESET_PC;
      buf_pc      <= '0;
      buf_instr   <= '0;
      pc          <= '0;
      instruction <= '0;
      valid       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_reg      <= pc_reg_nxt;
      buf_pc      <= buf_pc_nxt;
      buf_instr   <= buf_instr_nxt;
      pc          <= pc_nxt;
      instruction <= instruction_nxt;
      valid       <= valid_nxt;
    end
  end

`ifdef IF_STALL_COUNT_EN
  logic stall_evt;
  assign stall_evt = ((state == ST_FETCH) || (state == ST_WAIT) || (state == ST_KILL))
                     && !freeze && !deliver;

  // Saturating count of cycles the stage could have delivered but did not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall_evt && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + XLEN'(1);
    end
  end
`endif

endmodule
